inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the instruction buffer depth in entries; legal values are 2 and 4.
REQ-003 clk  in  1  is the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  is the reset: asynchronous assert, active-low.
REQ-005 mem_req_o  out  1  is the fetch request to instruction memory.
REQ-006 mem_addr_o  out  32  is the fetch address; it is word-aligned.
REQ-007 mem_ack_i  in  1  is a one-cycle pulse; mem_data_i is valid in that cycle.
REQ-008 mem_data_i  in  32  is the fetched instruction word.
REQ-009 stall_i  in  1  means the downstream stage is not accepting this cycle.
REQ-010 br_taken_i  in  1  is the redirect request from the execute stage (branch/jump resolved taken).
REQ-011 br_target_i  in  32  is the redirect address.
REQ-012 inst_valid_o  out  1  means pc_o and inst_o hold a valid instruction.
REQ-013 pc_o  out  32  is the address of the presented instruction.
REQ-014 inst_o  out  32  is the presented instruction word.

Function
REQ-015 The block SHALL hold a fetch_pc register, a BUF_DEPTH-entry FIFO of {pc, inst}, and a FSM with states IDLE, WAIT and DROP.
REQ-016 Credit rule: a new request SHALL issue only when fifo_count + outstanding < BUF_DEPTH, with at most 1 request outstanding.
REQ-017 IDLE -> WAIT when the credit rule holds and br_taken_i=0: mem_req_o<=1, mem_addr_o<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps mod 2^32).
REQ-018 In WAIT, mem_req_o and mem_addr_o SHALL stay stable until mem_ack_i.
REQ-019 On an ack in WAIT, {mem_addr_o, mem_data_i} SHALL be pushed; mem_req_o drops for at least 1 cycle; next state is IDLE.
REQ-020 A downstream transfer occurs when inst_valid_o=1 and stall_i=0; the FIFO head pops at that edge.
REQ-021 inst_valid_o SHALL equal fifo_count!=0; pc_o/inst_o SHALL show the head entry.
REQ-022 When the FIFO is empty, pc_o SHALL be 0 and inst_o SHALL be 32'h0000_0013 (NOP).
REQ-023 Latency: ack in cycle N gives inst_valid_o=1 in cycle N+1 if the FIFO was empty.
REQ-024 A push and a pop in the same cycle SHALL be allowed; the count is unchanged and order is preserved.
REQ-025 The FIFO SHALL never overflow; a push while full is impossible by REQ-016.
REQ-026 Redirect (br_taken_i=1) SHALL:
  - flush the FIFO (count 0) at that edge;
  - set fetch_pc<=br_target_i with bits [1:0] forced to 0;
  - drop mem_req_o.
REQ-027 Redirect in WAIT without ack -> DROP; DROP discards the next ack, then -> IDLE.
REQ-028 Redirect in the same cycle as an ack: the ack data SHALL be discarded; next state is IDLE.
REQ-029 Redirect has priority over push and pop in the same cycle.
REQ-030 A redirect while in DROP SHALL update fetch_pc and stay in DROP.
REQ-031 inst_valid_o SHALL be 0 in the cycle after a redirect.
REQ-032 After a redirect, the first presented instruction SHALL have pc_o equal to the aligned target.

Reset
REQ-033 rst_n=0 SHALL immediately set:
  - FSM=IDLE, fetch_pc=RESET_PC, fifo_count=0;
  - mem_req_o=0, mem_addr_o=0;
  - inst_valid_o=0, pc_o=0, inst_o=32'h0000_0013.
REQ-034 A reset during WAIT SHALL abandon the outstanding request; an ack arriving during or after reset SHALL be ignored until a new request issues.
REQ-035 The first mem_req_o=1 SHALL occur in the first clock edge after rst_n deasserts.

Verification
REQ-036 Reset release; memory acks 1 cycle after request with 32'h0050_0093 at address 0 -> inst_valid_o=1 the cycle after ack, pc_o=0, inst_o=32'h0050_0093; next mem_addr_o=4.
REQ-037 stall_i=1 for 8 cycles with BUF_DEPTH=2 -> exactly 2 entries buffered (pc 0,4); mem_req_o stays 0; on release, pc_o sequence is 0,4,8 with nothing lost or repeated.
REQ-038 br_taken_i with target 32'h100 while the request to 32'h8 is outstanding -> the ack for 0x8 is dropped, next mem_addr_o=32'h100, first valid pc_o=32'h100.
REQ-039 br_taken_i, mem_ack_i and a pop all in the same cycle -> FIFO empty next cycle, ack data absent, next request to the target.
REQ-040 br_target_i=32'h103 -> mem_addr_o=32'h100.
REQ-041 rst_n pulled low mid-WAIT -> all outputs take reset values asynchronously; a late ack produces no entry.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Instruction memory bus between the fetch unit (master) and instruction memory (slave).
interface inst_fetch_if;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;

   modport master (
      output mem_req_o,
      output mem_addr_o,
      input  mem_ack_i,
      input  mem_data_i
   );

   modport slave (
      input  mem_req_o,
      input  mem_addr_o,
      output mem_ack_i,
      output mem_data_i
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding memory request at a time, credit-limited by a small {pc, inst} FIFO.
//
// state | meaning
// IDLE  | nothing in flight; issues a request when the FIFO has room
// WAIT  | request outstanding, address held stable until ack
// DROP  | request abandoned by a redirect; the next ack is discarded
module inst_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   inst_fetch_if.master mem,
   input  logic         stall_i,
   input  logic         br_taken_i,
   input  logic [31:0]  br_target_i,
   output logic         inst_valid_o,
   output logic [31:0]  pc_o,
   output logic [31:0]  inst_o
);
   localparam int              PW      = (BUF_DEPTH > 2) ? 2 : 1;
   localparam int              CW      = PW + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(BUF_DEPTH);
   localparam logic [31:0]     NOP     = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t         state_q, state_d;
   logic [31:0]    fetch_pc_q, fetch_pc_d;
   logic           mem_req_q, mem_req_d;
   logic [31:0]    mem_addr_q, mem_addr_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [31:0]    pc_mem_q   [BUF_DEPTH];
   logic [31:0]    inst_mem_q [BUF_DEPTH];
   logic           push, pop;
   logic [31:0]    br_pc;

   assign br_pc = br_target_i & ~32'h3;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      push       = 1'b0;
      // redirect wins over both FIFO ports
      pop        = (count_q != '0) && !stall_i && !br_taken_i;
      case (state_q)
         IDLE: begin
            if (br_taken_i) begin
               fetch_pc_d = br_pc;
            end else if (count_q < DEPTH_C) begin
               state_d    = WAIT;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
         WAIT: begin
            if (br_taken_i) begin
               fetch_pc_d = br_pc;
               mem_req_d  = 1'b0;
               state_d    = mem.mem_ack_i ? IDLE : DROP;
            end else if (mem.mem_ack_i) begin
               push      = 1'b1;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         DROP: begin
            if (br_taken_i) begin
               fetch_pc_d = br_pc;
            end
            if (mem.mem_ack_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (br_taken_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // storage needs no reset: the head is only visible while count_q is non-zero
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= mem_addr_q;
         inst_mem_q[wr_ptr_q] <= mem.mem_data_i;
      end
   end

   assign mem.mem_req_o  = mem_req_q;
   assign mem.mem_addr_o = mem_addr_q;
   assign inst_valid_o   = (count_q != '0);
   assign pc_o           = inst_valid_o ? pc_mem_q[rd_ptr_q]   : 32'h0;
   assign inst_o         = inst_valid_o ? inst_mem_q[rd_ptr_q] : NOP;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model checked every cycle, directed scenarios, then random traffic.
module tb_inst_fetch;
   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] inst;

   int checks = 0;
   int errors = 0;

   inst_fetch_if bus ();

   inst_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem          (bus),
      .stall_i      (stall),
      .br_taken_i   (br_taken),
      .br_target_i  (br_target),
      .inst_valid_o (inst_valid),
      .pc_o         (pc),
      .inst_o       (inst)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] mq_pc[$];
   logic [31:0] mq_inst[$];
   logic [31:0] m_fpc;
   logic [31:0] m_addr;
   logic        m_req;
   logic        m_busy;
   logic        m_drop;
   int          m_sz;
   logic        m_pop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq_pc.delete();
         mq_inst.delete();
         m_fpc  = 32'h0;
         m_addr = 32'h0;
         m_req  = 1'b0;
         m_busy = 1'b0;
         m_drop = 1'b0;
      end else begin
         m_sz  = mq_pc.size();
         m_pop = (m_sz != 0) && !stall;
         if (br_taken) begin
            mq_pc.delete();
            mq_inst.delete();
            m_fpc = br_target & ~32'h3;
            if (m_busy) begin
               m_busy = 1'b0;
               m_req  = 1'b0;
               m_drop = !bus.mem_ack_i;
            end else if (m_drop && bus.mem_ack_i) begin
               m_drop = 1'b0;
            end
         end else begin
            if (m_pop) begin
               void'(mq_pc.pop_front());
               void'(mq_inst.pop_front());
            end
            if (m_busy) begin
               if (bus.mem_ack_i) begin
                  mq_pc.push_back(m_addr);
                  mq_inst.push_back(bus.mem_data_i);
                  m_busy = 1'b0;
                  m_req  = 1'b0;
               end
            end else if (m_drop) begin
               if (bus.mem_ack_i) m_drop = 1'b0;
            end else if (m_sz < DEPTH) begin
               m_busy = 1'b1;
               m_req  = 1'b1;
               m_addr = m_fpc;
               m_fpc  = m_fpc + 32'd4;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic e_valid;
      e_valid = (mq_pc.size() != 0);
      chk("cmp_valid", 32'(inst_valid), 32'(e_valid));
      chk("cmp_pc",    pc,   e_valid ? mq_pc[0]   : 32'h0);
      chk("cmp_inst",  inst, e_valid ? mq_inst[0] : NOP);
      chk("cmp_req",   32'(bus.mem_req_o), 32'(m_req));
      chk("cmp_addr",  bus.mem_addr_o, m_addr);
   end

   // ---------------- memory responder ----------------
   logic        mp_pend;
   int          mp_cnt;
   logic [31:0] mp_addr;
   int          mem_max_lat = 0;
   logic        last_ack;

   task automatic mem_tick();
      logic ack;
      ack = 1'b0;
      if (mp_pend) begin
         if (mp_cnt == 0) begin
            ack     = 1'b1;
            mp_pend = 1'b0;
         end else begin
            mp_cnt--;
         end
      end else if (bus.mem_req_o) begin
         mp_pend = 1'b1;
         mp_cnt  = int'($urandom_range(0, mem_max_lat));
         mp_addr = bus.mem_addr_o;
      end
      last_ack       = ack;
      bus.mem_ack_i  = ack;
      bus.mem_data_i = ack ? mem_word(mp_addr) : $urandom;
   endtask

   task automatic step(input logic st, input logic br, input logic [31:0] tgt);
      mem_tick();
      stall     = st;
      br_taken  = br;
      br_target = tgt;
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      mp_pend       = 1'b0;
      bus.mem_ack_i = 1'b0;
      stall         = 1'b0;
      br_taken      = 1'b0;
      br_target     = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_req(input string nm);
      for (int i = 0; i < 20 && !bus.mem_req_o; i++) step(1'b0, 1'b0, 32'h0);
      chk(nm, 32'(bus.mem_req_o), 32'h1);
   endtask

   task automatic wait_valid(input string nm);
      for (int i = 0; i < 20 && !inst_valid; i++) step(1'b0, 1'b0, 32'h0);
      chk(nm, 32'(inst_valid), 32'h1);
   endtask

   logic [31:0] got[$];

   initial begin
      rst_n         = 1'b0;
      stall         = 1'b0;
      br_taken      = 1'b0;
      br_target     = 32'h0;
      bus.mem_ack_i = 1'b0;
      bus.mem_data_i = 32'h0;
      mp_pend       = 1'b0;
      mp_cnt        = 0;
      mp_addr       = 32'h0;
      last_ack      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      chk("rst_pc",    pc, 32'h0);
      chk("rst_inst",  inst, NOP);
      chk("rst_req",   32'(bus.mem_req_o), 32'h0);
      chk("rst_addr",  bus.mem_addr_o, 32'h0);

      // first fetch, ack one cycle after request
      do_reset();
      step(1'b0, 1'b0, 32'h0);
      chk("first_req",   32'(bus.mem_req_o), 32'h1);
      chk("first_addr",  bus.mem_addr_o, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("wait_valid0", 32'(inst_valid), 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("lat_valid",   32'(inst_valid), 32'h1);
      chk("lat_pc",      pc, 32'h0);
      chk("lat_inst",    inst, 32'h0050_0093);
      chk("ack_req_low", 32'(bus.mem_req_o), 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("next_addr4",  bus.mem_addr_o, 32'h4);

      // stall fills the buffer, then drains in order
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (i >= 7) chk("full_noreq", 32'(bus.mem_req_o), 32'h0);
      end
      chk("full_pc0",    pc, 32'h0);
      chk("model_depth", 32'(mq_pc.size()), 32'h2);
      got.delete();
      for (int i = 0; i < 30 && got.size() < 3; i++) begin
         if (inst_valid) got.push_back(pc);
         step(1'b0, 1'b0, 32'h0);
      end
      chk("drain_cnt", 32'(got.size()), 32'h3);
      if (got.size() == 3) begin
         chk("drain_pc0", got[0], 32'h0);
         chk("drain_pc1", got[1], 32'h4);
         chk("drain_pc2", got[2], 32'h8);
      end

      // redirect while the request to 0x8 is outstanding
      do_reset();
      for (int i = 0; i < 30; i++) begin
         if (bus.mem_req_o && bus.mem_addr_o == 32'h8) break;
         step(1'b0, 1'b0, 32'h0);
      end
      chk("req_to_8", bus.mem_addr_o, 32'h8);
      step(1'b0, 1'b1, 32'h100);
      chk("br_valid0", 32'(inst_valid), 32'h0);
      chk("br_req0",   32'(bus.mem_req_o), 32'h0);
      wait_req("br_req_to");
      chk("br_addr",   bus.mem_addr_o, 32'h100);
      wait_valid("br_valid_to");
      chk("br_pc",     pc, 32'h100);

      // redirect, ack and pop in the same cycle
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
      chk("pre_valid", 32'(inst_valid), 32'h1);
      chk("pre_addr4", bus.mem_addr_o, 32'h4);
      step(1'b0, 1'b1, 32'h200);
      chk("same_ack",   32'(last_ack), 32'h1);
      chk("same_empty", 32'(inst_valid), 32'h0);
      chk("same_req0",  32'(bus.mem_req_o), 32'h0);
      wait_req("same_req_to");
      chk("same_addr",  bus.mem_addr_o, 32'h200);
      wait_valid("same_valid_to");
      chk("same_pc",    pc, 32'h200);

      // unaligned target in IDLE with a full buffer
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h103);
      chk("al_valid0", 32'(inst_valid), 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("al_req",    32'(bus.mem_req_o), 32'h1);
      chk("al_addr",   bus.mem_addr_o, 32'h100);

      // asynchronous reset in WAIT, ack arriving late
      do_reset();
      mem_max_lat = 2;
      step(1'b0, 1'b0, 32'h0);
      chk("ar_req1", 32'(bus.mem_req_o), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_req",   32'(bus.mem_req_o), 32'h0);
      chk("ar_addr",  bus.mem_addr_o, 32'h0);
      chk("ar_valid", 32'(inst_valid), 32'h0);
      chk("ar_pc",    pc, 32'h0);
      chk("ar_inst",  inst, NOP);
      mp_pend        = 1'b0;
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = 32'hDEAD_BEEF;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("late_valid0", 32'(inst_valid), 32'h0);
      chk("late_req",    32'(bus.mem_req_o), 32'h1);
      chk("late_addr",   bus.mem_addr_o, 32'h0);
      wait_valid("late_valid_to");
      chk("late_pc",     pc, 32'h0);
      chk("late_inst",   inst, 32'h0050_0093);

      // random traffic against the model
      do_reset();
      mem_max_lat = 2;
      for (int i = 0; i < 4000; i++) begin
         if (i % 1500 == 750) do_reset();
         step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
